// File: rtl/instruction_fetch_if.sv
// Instruction-fetch bundle: RAM read port B plus the decode-side handshake.
// master = fetch stage, slave = RAM/decode environment.
interface instruction_fetch_if #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [15:0]       dob;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              inst_valid;
    logic              inst_ready;
    logic [7:0]        inst_op;
    logic [7:0]        inst_regnum;
    logic [15:0]       inst_address_num;
    logic [ADDR_W-1:0] inst_pc;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output enb, addrb,
        input  dob,
        input  redirect_valid, redirect_addr,
        output inst_valid,
        input  inst_ready,
        output inst_op, inst_regnum, inst_address_num, inst_pc,
        output fifo_count
    );

    modport slave (
        input  enb, addrb,
        output dob,
        output redirect_valid, redirect_addr,
        input  inst_valid,
        output inst_ready,
        input  inst_op, inst_regnum, inst_address_num, inst_pc,
        input  fifo_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Prefetch stage: pairs 16-bit RAM words into {op,regnum,address_num}
// instructions and queues them for decode; redirect flushes everything.
module instruction_fetch #(
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                 clkb,
    input logic                 rst,
    instruction_fetch_if.master fetch
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [7:0]        op;
        logic [7:0]        regnum;
        logic [15:0]       num;
    } entry_t;

    entry_t            r_fifo [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_half;
    logic              r_resp_pending;
    logic              r_resp_half;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [7:0]        r_w0_op;
    logic [7:0]        r_w0_regnum;
    logic [ADDR_W-1:0] r_w0_pc;

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_redirect;
    logic              w_enb;
    logic              w_w1_resp;
    logic [CNT_W-1:0]  w_occ;
    entry_t            w_head;
    entry_t            w_new;

    always_comb begin
        w_valid    = (r_count != '0);
        w_pop      = w_valid & fetch.inst_ready;
        w_redirect = fetch.redirect_valid;
        w_w1_resp  = r_resp_pending & r_resp_half;
        w_push     = w_w1_resp & ~w_redirect;
        // Slot reserved by an issued word0 counts until its pair is pushed.
        w_occ = r_count - CNT_W'(w_pop) + CNT_W'(w_w1_resp);
        w_enb = rst & ~w_redirect
              & (r_half | (w_occ < CNT_W'(DEPTH)));
        w_head = r_fifo[r_head];
        w_new  = '{pc: r_w0_pc, op: r_w0_op,
                   regnum: r_w0_regnum, num: fetch.dob};
    end

    assign fetch.enb              = w_enb;
    assign fetch.addrb            = w_enb ? r_fetch_pc : '0;
    assign fetch.inst_valid       = w_valid;
    assign fetch.inst_op          = w_valid ? w_head.op : '0;
    assign fetch.inst_regnum      = w_valid ? w_head.regnum : '0;
    assign fetch.inst_address_num = w_valid ? w_head.num : '0;
    assign fetch.inst_pc          = w_valid ? w_head.pc : '0;
    assign fetch.fifo_count       = r_count;

    always_ff @(posedge clkb) begin
        if (!rst) begin
            r_fetch_pc     <= RESET_PC;
            r_half         <= 1'b0;
            r_resp_pending <= 1'b0;
            r_resp_half    <= 1'b0;
            r_resp_pc      <= '0;
            r_w0_op        <= '0;
            r_w0_regnum    <= '0;
            r_w0_pc        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
        end else begin
            // w_enb is 0 during a redirect, so this also kills its response.
            r_resp_pending <= w_enb;
            r_resp_half    <= r_half;
            r_resp_pc      <= r_fetch_pc;
            if (w_redirect) begin
                r_fetch_pc <= fetch.redirect_addr;
                r_half     <= 1'b0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else begin
                if (w_enb) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                    r_half     <= ~r_half;
                end
                if (r_resp_pending && !r_resp_half) begin
                    r_w0_op     <= fetch.dob[15:8];
                    r_w0_regnum <= fetch.dob[7:0];
                    r_w0_pc     <= r_resp_pc;
                end
                if (w_push) r_tail <= r_tail + PTR_W'(1);
                if (w_pop) r_head <= r_head + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clkb) begin
        if (w_push) r_fifo[r_tail] <= w_new;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios push expected
// instructions; a negedge monitor pops and compares on every handshake.
module tb_instruction_fetch;
    typedef struct packed {
        logic [9:0]  pc;
        logic [7:0]  op;
        logic [7:0]  rg;
        logic [15:0] num;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] mem [1024];
    exp_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    instruction_fetch_if #(.ADDR_W(10), .DEPTH(4)) bus ();

    instruction_fetch #(
        .ADDR_W(10), .DEPTH(4), .RESET_PC(10'd0)
    ) dut (
        .clkb (clk),
        .rst  (rst),
        .fetch(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.enb) bus.dob <= mem[bus.addrb];
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [9:0] pc, input logic [7:0] op,
                                input logic [7:0] rg, input logic [15:0] num);
        exp_t e;
        e.pc = pc; e.op = op; e.rg = rg; e.num = num;
        return e;
    endfunction

    function automatic exp_t model_at(input logic [9:0] pc);
        logic [9:0]  pc1;
        logic [15:0] w0;
        pc1 = pc + 10'd1;
        w0  = mem[pc];
        return mk(pc, w0[15:8], w0[7:0], mem[pc1]);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got pc %0h, expected none",
                         bus.inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("pop", {bus.inst_pc, bus.inst_op, bus.inst_regnum,
                              bus.inst_address_num}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        bus.inst_ready = 1'b0;
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_count(input logic [2:0] n);
        int k;
        k = 0;
        while (bus.fifo_count != n && k < 50) begin
            step();
            k++;
        end
        check("wait_count", bus.fifo_count, n);
    endtask

    task automatic do_redirect(input logic [9:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = a;
        step();
        bus.redirect_valid = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.inst_ready     = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = 16'(a) ^ 16'hA5C3;
        mem[0] = 16'h0401; mem[1] = 16'h1234;
        mem[2] = 16'h0502; mem[3] = 16'h0001;
        mem[1022] = 16'hAB10; mem[1023] = 16'hCD20;
        step();
        step();

        @(negedge clk);
        check("rst_enb", bus.enb, 0);
        check("rst_addrb", bus.addrb, 0);
        check("rst_valid", bus.inst_valid, 0);
        check("rst_op", bus.inst_op, 0);
        check("rst_reg", bus.inst_regnum, 0);
        check("rst_num", bus.inst_address_num, 0);
        check("rst_pc", bus.inst_pc, 0);
        check("rst_count", bus.fifo_count, 0);

        // boot fetch
        exp_q.push_back(mk(10'd0, 8'h04, 8'h01, 16'h1234));
        exp_q.push_back(mk(10'd2, 8'h05, 8'h02, 16'h0001));
        step();
        rst = 1'b1;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check("c0_enb", bus.enb, 1);
        check("c0_addrb", bus.addrb, 0);
        check("c0_valid", bus.inst_valid, 0);
        step(); @(negedge clk); check("c1_addrb", bus.addrb, 1);
        step(); @(negedge clk); check("c2_valid", bus.inst_valid, 0);
        step(); @(negedge clk); check("c3_valid", bus.inst_valid, 1);
        step(); @(negedge clk); check("c4_valid", bus.inst_valid, 0);
        step(); @(negedge clk); check("c5_valid", bus.inst_valid, 1);
        step();
        bus.inst_ready = 1'b0;
        check("boot_q", exp_q.size(), 0);

        // backpressure from reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (20) step();
        @(negedge clk);
        check("bp_full", bus.fifo_count, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_enb", bus.enb, 0);
            step();
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(model_at(10'(2 * i)));
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_enb", bus.enb, 1);
        check("bp_resume_addr", bus.addrb, 8);
        wait_drain("bp_drain");

        // redirect while word0 of pc 6 returns
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model_at(10'(2 * i)));
        repeat (6) step();
        @(negedge clk);
        check("mp_addr6", bus.addrb, 6);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 10'h100;
        @(negedge clk);
        check("mp_redir_enb", bus.enb, 0);
        step();
        bus.redirect_valid = 1'b0;
        check("mp_q", exp_q.size(), 0);
        exp_q.push_back(model_at(10'h100));
        exp_q.push_back(model_at(10'h102));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("mp_valid", bus.inst_valid, (i == 4) ? 1 : 0);
            if (i < 4) step();
        end
        wait_drain("mp_drain");

        // redirect with a same-cycle pop
        do_redirect(10'h040);
        wait_count(3'd3);
        exp_q.push_back(model_at(10'h040));
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 10'h020;
        step();
        bus.redirect_valid = 1'b0;
        check("rp_popped", exp_q.size(), 0);
        exp_q.push_back(model_at(10'h020));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("rp_valid", bus.inst_valid, (i == 4) ? 1 : 0);
            if (i < 4) check("rp_count", bus.fifo_count, 0);
            if (i < 4) step();
        end
        wait_drain("rp_drain");

        // address wrap
        do_redirect(10'd1022);
        exp_q.push_back(mk(10'd1022, 8'hAB, 8'h10, 16'hCD20));
        exp_q.push_back(mk(10'd0, 8'h04, 8'h01, 16'h1234));
        bus.inst_ready = 1'b1;
        wait_drain("wrap1022");
        do_redirect(10'd1023);
        exp_q.push_back(mk(10'd1023, 8'hCD, 8'h20, 16'h0401));
        exp_q.push_back(mk(10'd1, 8'h12, 8'h34, 16'h0502));
        bus.inst_ready = 1'b1;
        wait_drain("wrap1023");

        // reset mid-operation
        do_redirect(10'h080);
        wait_count(3'd3);
        rst = 1'b0;
        @(negedge clk);
        check("mr_enb_low", bus.enb, 0);
        step();
        rst = 1'b1;
        exp_q.push_back(mk(10'd0, 8'h04, 8'h01, 16'h1234));
        exp_q.push_back(mk(10'd2, 8'h05, 8'h02, 16'h0001));
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check("mr_valid", bus.inst_valid, 0);
        check("mr_count", bus.fifo_count, 0);
        check("mr_enb", bus.enb, 1);
        check("mr_addrb", bus.addrb, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            @(negedge clk);
            check("mr_lat", bus.inst_valid, (i == 3) ? 1 : 0);
        end
        wait_drain("mr_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Prefetch stage directly upstream of the CPU decode stage. Streams 16-bit words from the instruction RAM read port, pairs them into complete instructions, and buffers them in a small FIFO. Each instruction is {op, regnum} in word 0 and {address_num} in word 1. Decode pops instructions over a valid/ready handshake and issues a redirect for jmp and loop-back, which flushes all prefetched state.

## Interface
- ADDR_W, 10, RAM word-address width; pc arithmetic is modulo 2^ADDR_W
- DEPTH, 4, instruction FIFO entries; power of two, >= 2
- RESET_PC, 0, fetch start address after reset
- clkb  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- enb  out  1  RAM port-B read enable
- addrb  out  ADDR_W  RAM read address
- dob  in  16  RAM read data, valid the cycle after the enb/addrb sample
- redirect_valid  in  1  flush and restart fetch
- redirect_addr  in  ADDR_W  new fetch address (any alignment)
- inst_valid  out  1  FIFO head holds an instruction
- inst_ready  in  1  decode accepts the head
- inst_op  out  8  head word0[15:8]
- inst_regnum  out  8  head word0[7:0]
- inst_address_num  out  16  head word1
- inst_pc  out  ADDR_W  address of head word0
- fifo_count  out  clog2(DEPTH)+1  buffered instructions

## Operation
- State: fetch_pc, half (0 = next read is word0, 1 = next read is word1), resp_pending with resp_half, word0 holding register, FIFO (head/tail pointers, count).
- occupancy = count + (1 if a word0 has been issued and its instruction is not yet pushed).
- Issue rule, combinational per cycle:
  - half=0: enb=1 only if occupancy < DEPTH and no redirect this cycle.
  - half=1: enb=1 unconditionally, because the slot was reserved at the word0 issue.
  - With enb=1: addrb=fetch_pc, fetch_pc advances by 1 (wraps), half toggles.
- Response:
  - resp_half=0: latch dob[15:8]/dob[7:0] plus its pc into word0.
  - resp_half=1: push {pc, op, regnum, dob} at the FIFO tail.
- Pop: inst_valid && inst_ready advances the head.
- Push and pop in the same cycle: count unchanged.
- FIFO outputs drive head-entry contents and are meaningful only when inst_valid=1.
- Redirect, highest priority:
  - A pop occurring in the same cycle completes; the consumer owns that instruction.
  - Then: count:=0, pointers cleared, half:=0, fetch_pc:=redirect_addr, pending partial word0 dropped.
  - A response arriving the cycle after the redirect is discarded (kill flag) and is never pushed or latched.
  - enb=0 in the redirect cycle.
- Back-to-back redirects: the last one wins, and each restarts the latency.
- Reset (rst=0 at a posedge): fetch_pc:=RESET_PC, half:=0, kill:=1, count:=0. Reset mid-operation discards everything, including an in-flight RAM read.

## Timing
- Reset values: enb=0, addrb=0, inst_valid=0, inst_op=0, inst_regnum=0, inst_address_num=0, inst_pc=0, fifo_count=0. While rst=0, enb is forced 0.
- Let C0 be the first cycle with rst=1, or the cycle after a redirect. Then:
  - C0: enb=1, addrb=pc.
  - C1: word0 on dob; addrb=pc+1.
  - C2: word1 on dob, pushed at the end of C2; next word0 issued.
  - C3: inst_valid=1.
- Latency: 3 cycles to the first inst_valid.
- Peak throughput: 1 instruction per 2 cycles (single read port).
- Full (occupancy=DEPTH): word0 issue stalls. It resumes in the same cycle as a pop, because the occupancy check uses count after the pop of that cycle.
- Empty: inst_valid=0, and inst_ready is ignored.
- No combinational path from inst_ready or redirect_valid to dob; enb/addrb may depend combinationally on both.

## Test plan
- Boot fetch:
  - Stimulus: RAM[0..3]=0x0401,0x1234,0x0502,0x0001; ready=1.
  - Required: C3 shows op=4, reg=1, num=0x1234, pc=0; C5 shows op=5, reg=2, num=0x0001, pc=2.
- Backpressure:
  - Stimulus: ready=0 from reset.
  - Required: fifo_count reaches 4 and enb stays 0 with no further reads. After ready=1, pcs 0,2,4,6,8… are delivered in order with no gaps or duplicates.
- Redirect mid-pair:
  - Stimulus: redirect to 0x100 in the cycle word0 at pc 6 returns.
  - Required: no pc-6 instruction is emitted; the next valid has pc=0x100, 3 cycles after the redirect.
- Redirect with pop:
  - Stimulus: count=3, ready=1, redirect to 0x20 in the same cycle.
  - Required: the head is consumed; the next cycle has fifo_count=0 and inst_valid=0; the stale dob is not pushed.
- Wrap:
  - Stimulus: redirect to 1022.
  - Required: instruction pc=1022 (words 1022/1023), then pc=0.
  - Stimulus: redirect to 1023.
  - Required: instruction pc=1023, word0 from 1023 and word1 from 0.
- Reset mid-operation:
  - Stimulus: rst=0 for 1 cycle with count=3 and a read in flight.
  - Required: inst_valid=0, fifo_count=0, enb=0; fetch restarts at RESET_PC with first valid 3 cycles after release.
